// File: rtl/rv_decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_decode_pkg
//  Brief    : Opcode constants, skid-state encoding and decoded bundle type
//             shared by the instruction-decode immediate stage.
//  Revision : 1.0
// ============================================================================
package rv_decode_pkg;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        illegal;
    } bundle_t;

    // Value the output register shows whenever it holds nothing.
    function automatic bundle_t idle_bundle(input logic [31:0] pc);
        bundle_t b;
        b    = '0;
        b.pc = pc;
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/signex12.sv
`default_nettype none
// ============================================================================
//  Module   : signex12
//  Brief    : Sign-extends a 12-bit immediate to 32 bits.
//  Revision : 1.0
// ============================================================================
module signex12 (
    input  logic [11:0] imm12_i,
    output logic [31:0] imm_o
);

    assign imm_o = {{20{imm12_i[11]}}, imm12_i};

endmodule
`default_nettype wire

// File: rtl/id_imm_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_imm_stage
//  Brief    : Decode stage extracting register fields and the sign-extended
//             12-bit immediate, with a 2-entry skid buffer and flush.
//  Revision : 1.0
// ============================================================================
module id_imm_stage
    import rv_decode_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [31:0]     out_imm,
    output logic            out_illegal
);

    state_e      state_q, state_d;
    bundle_t     out_q, out_d;
    bundle_t     skid_q, skid_d;
    logic        in_ready_q;
    logic        out_valid_q;

    logic [11:0] w_imm12;
    logic        w_illegal;
    logic [31:0] w_imm;
    bundle_t     w_dec;
    logic        w_accept;
    logic        w_xfer;

    // Decode on the input side so the skid entry holds finished bundles.
    always_comb begin
        w_imm12   = 12'd0;
        w_illegal = 1'b0;
        case (in_instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR: w_imm12 = in_instr[31:20];
            OP_STORE:                 w_imm12 = {in_instr[31:25], in_instr[11:7]};
            OP_REG:                   w_imm12 = 12'd0;
            default:                  w_illegal = 1'b1;
        endcase
    end

    signex12 u_signex12 (
        .imm12_i (w_imm12),
        .imm_o   (w_imm)
    );

    always_comb begin
        w_dec         = '0;
        w_dec.pc      = in_pc;
        w_dec.opcode  = in_instr[6:0];
        w_dec.rd      = in_instr[11:7];
        w_dec.rs1     = in_instr[19:15];
        w_dec.rs2     = in_instr[24:20];
        w_dec.funct3  = in_instr[14:12];
        w_dec.funct7  = in_instr[31:25];
        w_dec.imm     = w_imm;
        w_dec.illegal = w_illegal;
    end

    assign w_accept = in_valid & in_ready_q;
    assign w_xfer   = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (w_accept) begin
                    out_d   = w_dec;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (w_accept && w_xfer) begin
                    out_d = w_dec;
                end else if (w_accept) begin
                    skid_d  = w_dec;
                    state_d = SKID;
                end else if (w_xfer) begin
                    out_d   = idle_bundle(RESET_PC);
                    state_d = EMPTY;
                end
            end
            SKID: begin
                if (w_xfer) begin
                    out_d   = skid_q;
                    state_d = FULL;
                end
            end
            default: begin
                out_d   = idle_bundle(RESET_PC);
                state_d = EMPTY;
            end
        endcase
        // Flush wins over any accept; a same-cycle transfer already happened.
        if (flush) begin
            out_d   = idle_bundle(RESET_PC);
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_q       <= idle_bundle(RESET_PC);
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != SKID);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_pc      = out_q.pc;
    assign out_opcode  = out_q.opcode;
    assign out_rd      = out_q.rd;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_funct3  = out_q.funct3;
    assign out_funct7  = out_q.funct7;
    assign out_imm     = out_q.imm;
    assign out_illegal = out_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_imm_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_imm_stage
//  Brief    : Self-checking bench for id_imm_stage using a queue-based model.
//  Revision : 1.0
// ============================================================================
module tb_id_imm_stage;

    localparam logic [31:0] c_RESET_PC = 32'hDEAD_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        illegal;
    } tb_bundle_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        illegal;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic        out_illegal;

    int errors = 0;
    int checks = 0;
    tb_bundle_t q[$];

    always #5 clk = ~clk;

    id_imm_stage #(.XLEN(32), .RESET_PC(c_RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_imm     (out_imm),
        .out_illegal (out_illegal)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode written directly from the immediate-format rules.
    function automatic tb_bundle_t dec_ref(input logic [31:0] ins, input logic [31:0] pc);
        tb_bundle_t b;
        int         v;
        logic [11:0] i12;
        b = '0;
        i12 = 12'd0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: i12 = ins[31:20];
            7'h23:               i12 = {ins[31:25], ins[11:7]};
            7'h33:               i12 = 12'd0;
            default:             b.illegal = 1'b1;
        endcase
        v = int'(i12);
        if (v >= 2048) v = v - 4096;
        b.imm    = 32'(v);
        b.pc     = pc;
        b.opcode = ins[6:0];
        b.rd     = ins[11:7];
        b.rs1    = ins[19:15];
        b.rs2    = ins[24:20];
        b.funct3 = ins[14:12];
        b.funct7 = ins[31:25];
        return b;
    endfunction

    task automatic check_outputs();
        tb_bundle_t act;
        tb_bundle_t exp;
        act = {out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3,
               out_funct7, out_imm, out_illegal};
        exp = '0;
        exp.pc = c_RESET_PC;
        if (q.size() > 0) exp = q[0];
        chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
        chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
        chk("bundle", 128'(act), 128'(exp));
    endtask

    // Advance one clock: update the model with the pre-edge view, then compare.
    task automatic tick();
        bit acc;
        bit xfer;
        @(posedge clk);
        acc  = in_valid && (q.size() < 2);
        xfer = (q.size() > 0) && out_ready;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (xfer) void'(q.pop_front());
            if (acc)  q.push_back(dec_ref(in_instr, in_pc));
        end
        #1;
        check_outputs();
    endtask

    task automatic fill_two(input logic [31:0] pc_a, input logic [31:0] pc_b);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        in_pc     = pc_a;
        tick();
        in_instr  = 32'h00200113;
        in_pc     = pc_b;
        tick();
        in_valid  = 1'b0;
        chk("fill_skid_ready", 128'(in_ready), 128'(0));
    endtask

    vec_t        vecs[8];
    logic [6:0]  ops[6];

    initial begin
        vecs[0] = '{32'hFFF00093, 32'h100, 32'hFFFFFFFF, 1'b0, 5'd1, 5'd0, 5'd31, 3'd0};
        vecs[1] = '{32'hFE20AE23, 32'h104, 32'hFFFFFFFC, 1'b0, 5'd28, 5'd1, 5'd2, 3'd2};
        vecs[2] = '{32'h7FF00093, 32'h108, 32'h000007FF, 1'b0, 5'd1, 5'd0, 5'd31, 3'd0};
        vecs[3] = '{32'h80000093, 32'h10C, 32'hFFFFF800, 1'b0, 5'd1, 5'd0, 5'd0, 3'd0};
        vecs[4] = '{32'h0000007F, 32'h110, 32'h00000000, 1'b1, 5'd0, 5'd0, 5'd0, 3'd0};
        vecs[5] = '{32'h002081B3, 32'h114, 32'h00000000, 1'b0, 5'd3, 5'd1, 5'd2, 3'd0};
        vecs[6] = '{32'h00852283, 32'h118, 32'h00000008, 1'b0, 5'd5, 5'd10, 5'd8, 3'd2};
        vecs[7] = '{32'h000080E7, 32'h11C, 32'h00000000, 1'b0, 5'd1, 5'd1, 5'd0, 3'd0};
        ops[0] = 7'h13; ops[1] = 7'h03; ops[2] = 7'h67;
        ops[3] = 7'h23; ops[4] = 7'h33; ops[5] = 7'h7F;

        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single-instruction decode table, stage empty, consumer ready.
        for (int i = 0; i < 8; i++) begin
            in_instr  = vecs[i].instr;
            in_pc     = vecs[i].pc;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            chk("tbl_valid",   128'(out_valid),   128'(1));
            chk("tbl_pc",      128'(out_pc),      128'(vecs[i].pc));
            chk("tbl_opcode",  128'(out_opcode),  128'(vecs[i].instr[6:0]));
            chk("tbl_imm",     128'(out_imm),     128'(vecs[i].imm));
            chk("tbl_illegal", 128'(out_illegal), 128'(vecs[i].illegal));
            chk("tbl_rd",      128'(out_rd),      128'(vecs[i].rd));
            chk("tbl_rs1",     128'(out_rs1),     128'(vecs[i].rs1));
            chk("tbl_rs2",     128'(out_rs2),     128'(vecs[i].rs2));
            chk("tbl_funct3",  128'(out_funct3),  128'(vecs[i].f3));
            tick();
        end

        // Backpressure: A, B, C with consumer stalled, then drain in order.
        fill_two(32'hA00, 32'hB00);
        in_valid = 1'b1; in_instr = 32'h00300193; in_pc = 32'hC00;
        tick();
        chk("bp_hold_a", 128'(out_pc), 128'(32'hA00));
        chk("bp_c_blocked", 128'(in_ready), 128'(0));
        out_ready = 1'b1;
        tick();
        chk("bp_b_out", 128'(out_pc), 128'(32'hB00));
        tick();
        in_valid = 1'b0;
        chk("bp_c_out", 128'(out_pc), 128'(32'hC00));
        chk("bp_no_gap", 128'(out_valid), 128'(1));
        tick();
        chk("bp_drained", 128'(out_valid), 128'(0));

        // Flush in SKID with a new instruction presented.
        fill_two(32'hA10, 32'hB10);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00400213; in_pc = 32'hD10;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 128'(out_valid), 128'(0));
        chk("flush_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        tick();
        chk("flush_no_leak", 128'(out_valid), 128'(0));

        // Reset in SKID.
        fill_two(32'hA20, 32'hB20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_ready", 128'(in_ready), 128'(1));
        chk("rst_pc",    128'(out_pc),    128'(c_RESET_PC));

        // Randomized traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 79) == 0);
            in_instr  = $urandom;
            if ($urandom_range(0, 7) != 0) in_instr[6:0] = ops[$urandom_range(0, 5)];
            in_pc     = $urandom;
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
